// File: rtl/data_mem_stage.sv
// data_mem_stage
//   Data-memory stage placed after the ALU of the single-cycle CPU. The ALU
//   result is used as a byte address for word loads and stores against an
//   internal array. Each access takes LATENCY cycles of stall (including the
//   accept cycle) followed by a one-cycle DONE state that pulses done.
//
// Parameters
//   SIZE        data/address width
//   DEPTH_LOG2  log2 of the number of words in the array
//   LATENCY     stall cycles per access including the accept cycle (1..15)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   addr       byte address (word index = addr[DEPTH_LOG2+1:2])
//   wdata      store data
//   mem_read   load request
//   mem_write  store request (wins over mem_read)
//   rdata      last completed load data
//   stall      hold PC/CPU state this cycle
//   done       one-cycle pulse when an access completes
//   misalign   request with addr[1:0] != 0; the access is suppressed
//
// Optional feature (macro DMEM_STATS_EN)
//   Adds rd_count / wr_count: saturating 16-bit counts of completed loads
//   and stores since reset.

module data_mem_stage #(
  parameter int SIZE       = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] addr,
  input  logic [SIZE-1:0] wdata,
  input  logic            mem_read,
  input  logic            mem_write,
  output logic [SIZE-1:0] rdata,
  output logic            stall,
  output logic            done,
  output logic            misalign
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]     rd_count,
  output logic [15:0]     wr_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r;
  logic [3:0]              cnt_r;
  logic [DEPTH_LOG2-1:0]   idx_r;
  logic [SIZE-1:0]         wdata_r;
  logic                    op_write_r;
  logic [SIZE-1:0]         rdata_r;
  logic                    done_r;
  logic [SIZE-1:0]         mem_r [DEPTH];

  logic                    req_s;
  logic                    aligned_s;
  logic                    accept_s;
  logic [DEPTH_LOG2-1:0]   idx_s;
  logic                    addr_unused_s;

  assign req_s     = mem_read | mem_write;
  assign aligned_s = (addr[1:0] == 2'b00);
  assign idx_s     = addr[DEPTH_LOG2+1:2];
  assign accept_s  = (state_r == IDLE) && req_s && aligned_s;

  // Upper address bits are deliberately dropped so addresses wrap modulo depth.
  assign addr_unused_s = ^addr[SIZE-1:DEPTH_LOG2+2];

  assign rdata = rdata_r;
  assign done  = done_r;

  // Stall and misalign decode; both must react in the request cycle itself.
  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    case (state_r)
      IDLE: begin
        stall    = req_s & aligned_s;
        misalign = req_s & ~aligned_s;
      end
      BUSY: begin
        stall    = 1'b1;
        misalign = 1'b0;
      end
      DONE: begin
        stall    = 1'b0;
        misalign = 1'b0;
      end
      default: begin
        stall    = 1'b0;
        misalign = 1'b0;
      end
    endcase
  end

  // Access FSM, request latches, load data register and the memory array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      idx_r      <= {DEPTH_LOG2{1'b0}};
      wdata_r    <= {SIZE{1'b0}};
      op_write_r <= 1'b0;
      rdata_r    <= {SIZE{1'b0}};
      done_r     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {SIZE{1'b0}};
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            idx_r      <= idx_s;
            wdata_r    <= wdata;
            op_write_r <= mem_write;
            if (LATENCY > 1) begin
              state_r <= BUSY;
              cnt_r   <= 4'(LATENCY - 1);
            end else begin
              // Single-cycle latency: go straight to DONE, load data now.
              state_r <= DONE;
              done_r  <= 1'b1;
              if (!mem_write) begin
                rdata_r <= mem_r[idx_s];
              end else begin
                rdata_r <= rdata_r;
              end
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r == 4'd1) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            // Load data becomes visible on the edge entering DONE.
            if (!op_write_r) begin
              rdata_r <= mem_r[idx_r];
            end else begin
              rdata_r <= rdata_r;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE: begin
          // Stores commit on the edge leaving DONE, so reset in BUSY/DONE aborts them.
          if (op_write_r) begin
            mem_r[idx_r] <= wdata_r;
          end else begin
            mem_r[idx_r] <= mem_r[idx_r];
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_STATS_EN
  logic [15:0] rd_count_r;
  logic [15:0] wr_count_r;

  assign rd_count = rd_count_r;
  assign wr_count = wr_count_r;

  // Saturating per-type completion counters, stepped once per DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count_r <= 16'd0;
      wr_count_r <= 16'd0;
    end else if (state_r == DONE) begin
      if (op_write_r) begin
        if (wr_count_r != 16'hFFFF) begin
          wr_count_r <= wr_count_r + 16'd1;
        end else begin
          wr_count_r <= wr_count_r;
        end
      end else begin
        if (rd_count_r != 16'hFFFF) begin
          rd_count_r <= rd_count_r + 16'd1;
        end else begin
          rd_count_r <= rd_count_r;
        end
      end
    end else begin
      rd_count_r <= rd_count_r;
      wr_count_r <= wr_count_r;
    end
  end
`endif

endmodule
